// File: rtl/pattern_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pattern_pkg                                                        |
// | Shared states, default parameters and length/period clamp helpers  |
// | for the pattern_player LED sequencer.                              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pattern_pkg;

  localparam int DEF_N_LED    = 8;
  localparam int DEF_IDX_W    = 3;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_LVL_W    = 2;
  localparam int DEF_BASE_LEN = 4;
  localparam int DEF_LEN_STEP = 4;
  localparam int DEF_PERIOD0  = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHOW = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SHOW = S_SHOW,
    ST_GAP  = S_GAP,
    ST_DONE = S_DONE
  } state_e;

  // Sequence length grows with level and is clamped to the store depth.
  function automatic int len_calc(input int base_len, input int len_step,
                                  input int depth, input int level);
    int raw;
    raw = base_len + level * len_step;
    return (raw > depth) ? depth : raw;
  endfunction

  // Ticks per phase halve with each level but never drop below one.
  function automatic int per_calc(input int period0, input int level);
    int p;
    p = period0 >> level;
    return (p < 1) ? 1 : p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | phase_timer                                                        |
// | Counts tick strobes up to a loadable terminal value and pulses     |
// | expire on the edge where the term-th tick is seen.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] term,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    expire = !clear && tick && (cnt_q == term - CNT_W'(1));
    cnt_d  = cnt_q;
    // Self-restart on expire so back-to-back phases start from zero.
    if (clear || expire) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pattern_player.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pattern_player                                                     |
// | Plays a stored sequence of LED indices as one-hot pulses, with     |
// | length and speed scaled by level. Define PATTERN_PLAYER_GAP_EN to  |
// | insert a dark GAP phase after every SHOW phase.                    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pattern_player
  import pattern_pkg::*;
#(
  parameter int N_LED    = DEF_N_LED,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LVL_W    = DEF_LVL_W,
  parameter int BASE_LEN = DEF_BASE_LEN,
  parameter int LEN_STEP = DEF_LEN_STEP,
  parameter int PERIOD0  = DEF_PERIOD0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic [LVL_W-1:0]  level,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IDX_W-1:0]  wr_data,
  output logic [N_LED-1:0]  led,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] step_idx
);

  localparam int PER_W = $clog2(PERIOD0 + 1);

  state_e              state_q, state_d;
  state_e              adv_state;
  logic [ADDR_W-1:0]   step_q, step_d, adv_step;
  logic [ADDR_W:0]     len_q, len_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic [IDX_W-1:0]    store_q [DEPTH];
  logic [IDX_W-1:0]    store_d [DEPTH];
  logic [IDX_W-1:0]    show_idx;
  logic                timer_clear;
  logic                timer_expire;
  logic                last_step;

  // Counter is held at zero outside playback so the acceptance-cycle tick is ignored.
  assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

  phase_timer #(
    .CNT_W (PER_W)
  ) u_phase_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .tick   (tick),
    .term   (per_q),
    .expire (timer_expire)
  );

  always_comb begin : store_write
    store_d = store_q;
    if ((state_q == ST_IDLE) && wr_en) begin
      store_d[wr_addr] = wr_data;
    end
  end

  assign last_step = ({1'b0, step_q} == (len_q - (ADDR_W + 1)'(1)));

  always_comb begin : step_advance
    adv_state = ST_SHOW;
    adv_step  = step_q + ADDR_W'(1);
    if (last_step) begin
      adv_state = ST_DONE;
      adv_step  = step_q;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    per_d   = per_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = (ADDR_W + 1)'(len_calc(BASE_LEN, LEN_STEP, DEPTH, int'(level)));
          per_d   = PER_W'(per_calc(PERIOD0, int'(level)));
          step_d  = '0;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (timer_expire) begin
`ifdef PATTERN_PLAYER_GAP_EN
          state_d = ST_GAP;
`else
          state_d = adv_state;
          step_d  = adv_step;
`endif
        end
      end
      ST_GAP: begin
`ifdef PATTERN_PLAYER_GAP_EN
        if (timer_expire) begin
          state_d = adv_state;
          step_d  = adv_step;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reading the post-write store lets a same-cycle write reach the first step.
  always_comb begin : led_next
    show_idx = store_d[step_d];
    led_d    = '0;
    if (state_d == ST_SHOW) begin
      for (int i = 0; i < N_LED; i++) begin
        led_d[i] = (show_idx == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      per_q   <= PER_W'(1);
      led_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      per_q   <= per_d;
      led_q   <= led_d;
      store_q <= store_d;
    end
  end

  assign led      = led_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign step_idx = step_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_player.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pattern_player                                                  |
// | Two pattern_player instances (default and clamped-length variant)  |
// | checked cycle by cycle against an elapsed-tick reference model.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_pattern_player;

  localparam int N_LED    = 8;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int LVL_W    = 2;
  localparam int LEN_STEP = 4;
  localparam int PERIOD0  = 8;
  localparam int BASE0    = 4;
  localparam int BASE1    = 12;
  localparam int MAX_CYC  = 2000;
`ifdef PATTERN_PLAYER_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              start;
  logic [LVL_W-1:0]  level;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic [N_LED-1:0]  led0, led1;
  logic              busy0, busy1, done0, done1;
  logic [ADDR_W-1:0] step0, step1;

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, playback is described only by ticks elapsed since start.
  int m_store [2][DEPTH];
  int m_mode  [2];
  int m_t     [2];
  int m_len   [2];
  int m_per   [2];
  int m_step  [2];

  always #5 clk = ~clk;

  pattern_player #(
    .N_LED(N_LED), .IDX_W(3), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LVL_W(LVL_W),
    .BASE_LEN(BASE0), .LEN_STEP(LEN_STEP), .PERIOD0(PERIOD0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .level(level),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[2:0]),
    .led(led0), .busy(busy0), .done(done0), .step_idx(step0)
  );

  pattern_player #(
    .N_LED(N_LED), .IDX_W(4), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LVL_W(LVL_W),
    .BASE_LEN(BASE1), .LEN_STEP(LEN_STEP), .PERIOD0(PERIOD0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .level(level),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .led(led1), .busy(busy1), .done(done1), .step_idx(step1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int a = 0; a < DEPTH; a++) m_store[i][a] = 0;
        m_mode[i] = 0;
        m_step[i] = 0;
      end else begin
        case (m_mode[i])
          0: begin
            if (wr_en) m_store[i][int'(wr_addr)] = (i == 0) ? int'(wr_data) % 8 : int'(wr_data);
            if (start) begin
              m_len[i] = ((i == 0) ? BASE0 : BASE1) + int'(level) * LEN_STEP;
              if (m_len[i] > DEPTH) m_len[i] = DEPTH;
              m_per[i] = PERIOD0 >> int'(level);
              if (m_per[i] < 1) m_per[i] = 1;
              m_t[i]    = 0;
              m_mode[i] = 1;
            end
          end
          1: begin
            if (tick) begin
              m_t[i]++;
              if (m_t[i] == m_len[i] * m_per[i] * (GAP + 1)) m_mode[i] = 2;
            end
          end
          default: m_mode[i] = 0;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] el;
    int ph, s, v;
    for (int i = 0; i < 2; i++) begin
      el = 0;
      if (m_mode[i] == 1) begin
        ph = m_t[i] / m_per[i];
        s  = (GAP != 0) ? ph / 2 : ph;
        m_step[i] = s;
        if (!((GAP != 0) && (ph % 2 == 1))) begin
          v = m_store[i][s];
          if (v < N_LED) el = 32'(1) << v;
        end
      end
      check((i == 0) ? "led0"  : "led1",  (i == 0) ? 32'(led0)  : 32'(led1),  el);
      check((i == 0) ? "busy0" : "busy1", (i == 0) ? 32'(busy0) : 32'(busy1), 32'(m_mode[i] != 0));
      check((i == 0) ? "done0" : "done1", (i == 0) ? 32'(done0) : 32'(done1), 32'(m_mode[i] == 2));
      check((i == 0) ? "step0" : "step1", (i == 0) ? 32'(step0) : 32'(step1), 32'(m_step[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic write_store(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = 4'(d);
    cycle();
    wr_en   = 1'b0;
  endtask

  // One playback round; tmode 1 = continuous tick, 4 = every 4th clk, else random.
  task automatic run_round(input int lvl, input int tmode, input bit noise, input int wdata,
                           output int first_led0, output int ticks0, output int ticks1);
    int n, dn0, dn1, e0, e1;
    ticks0 = 0; ticks1 = 0; dn0 = 0; dn1 = 0;
    level = LVL_W'(lvl);
    start = 1'b1;
    tick  = 1'($urandom_range(0, 1));
    if (wdata >= 0) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = 4'(wdata);
    end
    cycle();
    first_led0 = int'(led0);
    start = 1'b0; wr_en = 1'b0;
    e0 = m_len[0] * m_per[0] * (GAP + 1);
    e1 = m_len[1] * m_per[1] * (GAP + 1);
    n = 0;
    while ((m_mode[0] != 0 || m_mode[1] != 0) && n < MAX_CYC) begin
      case (tmode)
        1:       tick = 1'b1;
        4:       tick = (n % 4 == 3);
        default: tick = 1'($urandom_range(0, 1));
      endcase
      if (noise && m_mode[0] == 1 && m_mode[1] == 1 && $urandom_range(0, 3) == 0) begin
        start = 1'b1; wr_en = 1'b1;
        wr_addr = ADDR_W'($urandom); wr_data = 4'($urandom); level = LVL_W'($urandom);
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (tick && busy0 && !done0) ticks0++;
      if (tick && busy1 && !done1) ticks1++;
      cycle();
      if (done0) dn0++;
      if (done1) dn1++;
      n++;
    end
    start = 1'b0; wr_en = 1'b0; tick = 1'b0;
    check("round_bound", 32'(n < MAX_CYC), 32'd1);
    check("ticks0", 32'(ticks0), 32'(e0));
    check("ticks1", 32'(ticks1), 32'(e1));
    check("done_pulses0", 32'(dn0), 32'd1);
    check("done_pulses1", 32'(dn1), 32'd1);
  endtask

  initial begin
    int fl, t0, t1, n;
    rst = 1'b1; tick = 1'b0; start = 1'b0; level = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Reference pattern {2,5,5,0} at level 0, tick every 4 clk.
    write_store(0, 2); write_store(1, 5); write_store(2, 5); write_store(3, 0);
    run_round(0, 4, 1'b0, -1, fl, t0, t1);
    check("dir_first_led", 32'(fl), 32'h04);
    check("dir_ticks", 32'(t0), 32'(4 * 8 * (GAP + 1)));

    // Level 3 with continuous tick; instance 1 clamps from 24 to 16 steps.
    run_round(3, 1, 1'b1, -1, fl, t0, t1);
    check("lvl3_ticks0", 32'(t0), 32'(16 * (GAP + 1)));
    check("lvl3_ticks1", 32'(t1), 32'(16 * (GAP + 1)));

    // Repeated index 7; write issued together with start.
    write_store(1, 7); write_store(2, 7); write_store(3, 7);
    run_round(0, 1, 1'b0, 7, fl, t0, t1);
    check("same_cycle_wr_led", 32'(fl), 32'h80);
    write_store(0, 6);
    run_round(1, 0, 1'b1, 3, fl, t0, t1);
    check("wr_at_start_led", 32'(fl), 32'h08);

    // Reset while step 2 is showing.
    level = '0; start = 1'b1; tick = 1'b0;
    cycle();
    start = 1'b0; tick = 1'b1; n = 0;
    while (step0 != 2 && n < 200) begin
      cycle();
      n++;
    end
    check("reach_step2", 32'(step0), 32'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0; tick = 1'b0;
    check("rst_led", 32'(led0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    cycle();
    check("rst_no_done", 32'(done0), 32'd0);
    run_round(2, 1, 1'b0, -1, fl, t0, t1);
    check("rst_store_cleared", 32'(fl), 32'h01);

    // Randomized rounds.
    for (int r = 0; r < 14; r++) begin
      for (int w = 0; w < int'($urandom_range(0, 8)); w++) begin
        write_store(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
      end
      run_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1,
                fl, t0, t1);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
